bheap_scan_host: RTL

- Bus-master counterpart of the binary-heap benchmark array. The array is a bus responder; this block drives its global RD/WR/Addr/DataIn bus and samples its DataOut.
- Scan-loads NODES key values into the register chain, then writes the controller's cycle counter to launch heap steps.
- Polls the counter until it reaches zero, then scan-reads all NODES values back out over a valid/ready stream.
- Sits between a host-side stream source/sink and the heap array top level.

---
 rtl/bheap_scan_host.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/bheap_scan_host.sv
// ---------------------------------------------------------------------------
// bheap_scan_host
//
// Bus master for the binary-heap benchmark array. It runs one job per Start:
//   1. Scan-loads NODES keys from the input stream into the register chain
//      (each write to SCAN_ID shifts the chain one place toward the root).
//   2. Writes Cycles to the controller counter at CTRL_ID to launch heap steps.
//   3. Polls the counter (one read, one idle cycle) until it reads zero.
//   4. Scan-reads the NODES keys back, root first, onto the output stream.
//
// Ports:
//   Clk, Reset        clock, asynchronous active-low reset
//   Start, Cycles     job request (sampled in IDLE) and heap-step count
//   In_Valid/Ready/Data    key load stream
//   Out_Valid/Ready/Data   result stream
//   Busy, Done        job status (Busy = not IDLE, Done = one-cycle pulse)
//   BusRD, BusWR, BusAddr, BusWData, BusRData   array bus (outputs registered)
//   Error             only with BHEAP_HOST_TIMEOUT_EN: poll timeout flag
//
// Optional feature macro: BHEAP_HOST_TIMEOUT_EN adds parameter TIMEOUT and
// output Error; POLL then gives up after TIMEOUT nonzero counter reads.
// ---------------------------------------------------------------------------
module bheap_scan_host #(
  parameter int WIDTH   = 32,
  parameter int NODES   = 3,
  parameter int CWIDTH  = 8,
  parameter int SCAN_ID = 0,
  parameter int CTRL_ID = 1,
  parameter int ADDR_W  = 15,
  parameter int DATA_W  = 32
`ifdef BHEAP_HOST_TIMEOUT_EN
  , parameter int TIMEOUT = 1024
`endif
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic [CWIDTH-1:0] Cycles,
  input  logic              In_Valid,
  output logic              In_Ready,
  input  logic [WIDTH-1:0]  In_Data,
  output logic              Out_Valid,
  input  logic              Out_Ready,
  output logic [WIDTH-1:0]  Out_Data,
  output logic              Busy,
  output logic              Done,
  output logic              BusRD,
  output logic              BusWR,
  output logic [ADDR_W-1:0] BusAddr,
  output logic [DATA_W-1:0] BusWData,
  input  logic [DATA_W-1:0] BusRData
`ifdef BHEAP_HOST_TIMEOUT_EN
  , output logic            Error
`endif
);

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] LOAD       = 3'd1;
  localparam logic [2:0] KICK       = 3'd2;
  localparam logic [2:0] POLL       = 3'd3;
  localparam logic [2:0] DRAIN_RD   = 3'd4;
  localparam logic [2:0] DRAIN_WAIT = 3'd5;
  localparam logic [2:0] FIN        = 3'd6;

  localparam int NCW = $clog2(NODES + 1);

  logic [2:0]        stateReg;
  logic [CWIDTH-1:0] cyclesReg;
  logic [NCW-1:0]    nodeCntReg;
  // In POLL and DRAIN_RD: 0 = issue the read, 1 = read is on the bus, sample it.
  logic              phaseReg;

`ifdef BHEAP_HOST_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0]     pollCntReg;
`endif

  // Upper BusRData bits carry nothing for this block; fold them into a sink.
  logic unusedRData;
  assign unusedRData = ^BusRData;

  assign Busy     = (stateReg != IDLE);
  assign Done     = (stateReg == FIN);
  assign In_Ready = (stateReg == LOAD);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      stateReg   <= IDLE;
      cyclesReg  <= '0;
      nodeCntReg <= '0;
      phaseReg   <= 1'b0;
      BusRD      <= 1'b0;
      BusWR      <= 1'b0;
      BusAddr    <= '0;
      BusWData   <= '0;
      Out_Valid  <= 1'b0;
      Out_Data   <= '0;
`ifdef BHEAP_HOST_TIMEOUT_EN
      pollCntReg <= '0;
      Error      <= 1'b0;
`endif
    end else begin
      // Strobes are single-cycle; each state re-asserts them as needed.
      BusRD <= 1'b0;
      BusWR <= 1'b0;
      case (stateReg)
        IDLE: begin
          if (Start) begin
            cyclesReg  <= Cycles;
            nodeCntReg <= '0;
            stateReg   <= LOAD;
`ifdef BHEAP_HOST_TIMEOUT_EN
            Error      <= 1'b0;
`endif
          end
        end

        LOAD: begin
          if (In_Valid) begin
            BusWR    <= 1'b1;
            BusAddr  <= ADDR_W'(SCAN_ID);
            BusWData <= DATA_W'(In_Data);
            if (nodeCntReg == NCW'(NODES - 1)) begin
              // Counter is reused for the drain phase.
              nodeCntReg <= '0;
              stateReg   <= KICK;
            end else begin
              nodeCntReg <= nodeCntReg + NCW'(1);
            end
          end
        end

        KICK: begin
          BusWR    <= 1'b1;
          BusAddr  <= ADDR_W'(CTRL_ID);
          BusWData <= DATA_W'(cyclesReg);
          phaseReg <= 1'b0;
          stateReg <= POLL;
`ifdef BHEAP_HOST_TIMEOUT_EN
          pollCntReg <= '0;
`endif
        end

        POLL: begin
          if (!phaseReg) begin
            BusRD    <= 1'b1;
            BusAddr  <= ADDR_W'(CTRL_ID);
            phaseReg <= 1'b1;
          end else begin
            // The read is on the bus this cycle; its data is valid at this edge.
            phaseReg <= 1'b0;
            if (BusRData[CWIDTH-1:0] == '0) begin
              stateReg <= DRAIN_RD;
            end
`ifdef BHEAP_HOST_TIMEOUT_EN
            else if (pollCntReg == TW'(TIMEOUT - 1)) begin
              Error    <= 1'b1;
              stateReg <= FIN;
            end else begin
              pollCntReg <= pollCntReg + TW'(1);
            end
`endif
          end
        end

        DRAIN_RD: begin
          if (!phaseReg) begin
            BusRD    <= 1'b1;
            BusAddr  <= ADDR_W'(SCAN_ID);
            phaseReg <= 1'b1;
          end else begin
            phaseReg  <= 1'b0;
            Out_Data  <= BusRData[WIDTH-1:0];
            Out_Valid <= 1'b1;
            stateReg  <= DRAIN_WAIT;
          end
        end

        DRAIN_WAIT: begin
          // At least one cycle here separates consecutive scan reads, which
          // covers the array's one-cycle scan-capture lag.
          if (Out_Ready) begin
            Out_Valid  <= 1'b0;
            nodeCntReg <= nodeCntReg + NCW'(1);
            if (nodeCntReg == NCW'(NODES - 1)) begin
              stateReg <= FIN;
            end else begin
              stateReg <= DRAIN_RD;
            end
          end
        end

        FIN: begin
          stateReg <= IDLE;
        end

        default: begin
          stateReg <= IDLE;
        end
      endcase
    end
  end

endmodule
